wb_arbiter: RTL

Write-back arbiter that sits directly upstream of the register bank and drives its single write port (WE3/RA3/WD3). Each cycle it merges two result sources into one registered write: ALU results, which are never stalled, and load results, which arrive with variable latency through a valid/ready handshake. Load results are held in a small FIFO until the write port is free. The arbiter also reports pending-write hits so the issue logic can detect hazards.

---
 rtl/wb_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Register-bank write-back arbiter. ALU results take priority.
//               Load results queue in a FIFO and drain when the port is free.
//               Optional build macro: WB_ZERO_REG_EN, which treats register 0
//               as hard-wired zero.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         alu_valid,
    input  logic [ADDR_W-1:0]            alu_rd,
    input  logic [WIDTH-1:0]             alu_data,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic [ADDR_W-1:0]            ld_rd,
    input  logic [WIDTH-1:0]             ld_data,
    input  logic [ADDR_W-1:0]            q_ra1,
    input  logic [ADDR_W-1:0]            q_ra2,
    output logic                         q_hit1,
    output logic                         q_hit2,
    output logic                         WE3,
    output logic [ADDR_W-1:0]            RA3,
    output logic [WIDTH-1:0]             WD3,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0]   r_data [DEPTH];
    logic [ADDR_W-1:0]  r_rd   [DEPTH];
    logic [DEPTH-1:0]   r_vld;
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_alu_take;
    logic w_enq;
    logic w_pop;

    // Ready looks only at registered occupancy: a full FIFO never accepts,
    // even on an edge where it also pops.
    assign ld_ready = !RST && (r_count != c_CNT_W'(DEPTH));
    assign count    = r_count;

`ifdef WB_ZERO_REG_EN
    assign w_alu_take = alu_valid && (alu_rd != '0);
    assign w_enq      = ld_valid && ld_ready && (ld_rd != '0);
`else
    assign w_alu_take = alu_valid;
    assign w_enq      = ld_valid && ld_ready;
`endif

    assign w_pop = !w_alu_take && (r_count != '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            WE3 <= 1'b0;
            RA3 <= '0;
            WD3 <= '0;
        end else if (w_alu_take) begin
            WE3 <= 1'b1;
            RA3 <= alu_rd;
            WD3 <= alu_data;
        end else if (w_pop) begin
            WE3 <= 1'b1;
            RA3 <= r_rd[r_rptr];
            WD3 <= r_data[r_rptr];
        end else begin
            WE3 <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            // Pop and enqueue can never target the same slot: that would need
            // the FIFO to be both empty and full.
            if (w_pop) begin
                r_vld[r_rptr] <= 1'b0;
                r_rptr        <= r_rptr + 1'b1;
            end
            if (w_enq) begin
                r_vld[r_wptr] <= 1'b1;
                r_wptr        <= r_wptr + 1'b1;
            end
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_enq) begin
            r_rd[r_wptr]   <= ld_rd;
            r_data[r_wptr] <= ld_data;
        end
    end

    // Hazard query: any queued load or the write currently on the port.
    always_comb begin
        q_hit1 = WE3 && (RA3 == q_ra1);
        q_hit2 = WE3 && (RA3 == q_ra2);
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_rd[i] == q_ra1)) q_hit1 = 1'b1;
            if (r_vld[i] && (r_rd[i] == q_ra2)) q_hit2 = 1'b1;
        end
`ifdef WB_ZERO_REG_EN
        if (q_ra1 == '0) q_hit1 = 1'b0;
        if (q_ra2 == '0) q_hit2 = 1'b0;
`endif
    end

endmodule
`default_nettype wire
